// File: rtl/alu_regfile_pipe_if.sv
// Request/writeback/result bundle for the ALU + register file execute stage.
// master: decode/writeback/consumer side; slave: the execute stage itself.
interface alu_regfile_pipe_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) ();
  localparam int AW = $clog2(NREGS);

  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic            reg_write;
  logic            alu_src;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] imm;

  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] rd2_out;
  logic            eq;
  logic [AW-1:0]   rd_out;
  logic            wr_out;
  logic [XLEN-1:0] a0;

  modport master (
    output in_valid, rs1, rs2, rd, reg_write,
    output alu_src, alu_ctrl, imm,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready, out_valid, alu_out, rd2_out,
    input  eq, rd_out, wr_out, a0
  );

  modport slave (
    input  in_valid, rs1, rs2, rd, reg_write,
    input  alu_src, alu_ctrl, imm,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready, out_valid, alu_out, rd2_out,
    output eq, rd_out, wr_out, a0
  );
endinterface

// File: rtl/alu_regfile_pipe.sv
// Register file + ALU execute stage with registered valid/ready result.
// Ports: clk, rst (async, active-high), bus (alu_regfile_pipe_if.slave).
// ALU_MUL_EN: when defined, op 10 runs an XLEN-step shift-add multiplier;
// otherwise op 10 completes in one cycle with a zero result.
module alu_regfile_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_regfile_pipe_if.slave bus
);
  localparam int AW = $clog2(NREGS);
  localparam int SW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  // Register file
  logic [XLEN-1:0] rf_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // a0 is the raw architectural value, never bypassed
  if (NREGS > 10) begin : g_a0
    assign bus.a0 = rf_q[10];
  end else begin : g_no_a0
    assign bus.a0 = '0;
  end

  // Operand read with writeback bypass
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] op2;

  always_comb begin
    op1 = '0;
    if (bus.rs1 != '0) begin
      if (bus.wb_en && bus.wb_addr == bus.rs1) begin
        op1 = bus.wb_data;
      end else begin
        op1 = rf_q[bus.rs1];
      end
    end
  end

  always_comb begin
    rd2 = '0;
    if (bus.rs2 != '0) begin
      if (bus.wb_en && bus.wb_addr == bus.rs2) begin
        rd2 = bus.wb_data;
      end else begin
        rd2 = rf_q[bus.rs2];
      end
    end
  end

  assign op2 = bus.alu_src ? bus.imm : rd2;

  // Single-cycle ALU
  logic [SW-1:0]   shamt;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] alu_res;

  assign shamt = op2[SW-1:0];
  assign lt_s  = $signed(op1) < $signed(op2);
  assign lt_u  = op1 < op2;

  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      OP_ADD:  alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_AND:  alu_res = op1 & op2;
      OP_OR:   alu_res = op1 | op2;
      OP_XOR:  alu_res = op1 ^ op2;
      OP_SLL:  alu_res = op1 << shamt;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = $signed(op1) >>> shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      default: alu_res = '0;
    endcase
  end

  // Handshake
  logic vld_q;
  logic vld_d;
  logic idle;
  logic acc;
  logic is_mul;
  logic ld_alu;
  logic ld_mul;

  assign bus.in_ready = idle && (!vld_q || bus.out_ready);
  assign acc          = bus.in_valid && bus.in_ready;
  assign ld_alu       = acc && !is_mul;

  // Output registers
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] alu_d;
  logic [XLEN-1:0] rd2_q;
  logic [XLEN-1:0] rd2_d;
  logic            eq_q;
  logic            eq_d;
  logic [AW-1:0]   rdo_q;
  logic [AW-1:0]   rdo_d;
  logic            wr_q;
  logic            wr_d;

`ifdef ALU_MUL_EN
  localparam int         CW     = SW + 1;
  localparam logic [3:0] OP_MUL = 4'd10;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic [XLEN-1:0] mc_q;
  logic [XLEN-1:0] mc_d;
  logic [XLEN-1:0] mp_q;
  logic [XLEN-1:0] mp_d;
  logic [XLEN-1:0] macc_q;
  logic [XLEN-1:0] macc_d;
  logic [XLEN-1:0] mrd2_q;
  logic [XLEN-1:0] mrd2_d;
  logic [AW-1:0]   mrd_q;
  logic [AW-1:0]   mrd_d;
  logic            mwr_q;
  logic            mwr_d;
  logic            meq_q;
  logic            meq_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  assign idle   = (state_q == S_IDLE);
  assign is_mul = (bus.alu_ctrl == OP_MUL);

  // Multiplicand shifts left, multiplier shifts right; the
  // accumulator only ever needs the low XLEN product bits.
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    macc_d  = macc_q;
    mrd2_d  = mrd2_q;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    meq_d   = meq_q;
    cnt_d   = cnt_q;
    ld_mul  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (acc && is_mul) begin
          state_d = S_MUL;
          mc_d    = op1;
          mp_d    = op2;
          macc_d  = '0;
          cnt_d   = CW'(XLEN);
          mrd2_d  = rd2;
          mrd_d   = bus.rd;
          mwr_d   = bus.reg_write;
          meq_d   = (op1 == op2);
        end
      end
      S_MUL: begin
        if (cnt_q != '0) begin
          if (mp_q[0]) begin
            macc_d = macc_q + mc_q;
          end
          mc_d  = mc_q << 1;
          mp_d  = mp_q >> 1;
          cnt_d = cnt_q - 1'b1;
        end else if (!vld_q || bus.out_ready) begin
          ld_mul  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mc_q    <= '0;
      mp_q    <= '0;
      macc_q  <= '0;
      mrd2_q  <= '0;
      mrd_q   <= '0;
      mwr_q   <= 1'b0;
      meq_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mc_q    <= mc_d;
      mp_q    <= mp_d;
      macc_q  <= macc_d;
      mrd2_q  <= mrd2_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      meq_q   <= meq_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign idle   = 1'b1;
  assign is_mul = 1'b0;
  assign ld_mul = 1'b0;
`endif

  // A fresh load wins over the drop caused by out_ready
  always_comb begin
    vld_d = bus.out_ready ? 1'b0 : vld_q;
    alu_d = alu_q;
    rd2_d = rd2_q;
    eq_d  = eq_q;
    rdo_d = rdo_q;
    wr_d  = wr_q;
    if (ld_alu) begin
      vld_d = 1'b1;
      alu_d = alu_res;
      rd2_d = rd2;
      eq_d  = (op1 == op2);
      rdo_d = bus.rd;
      wr_d  = bus.reg_write;
    end
`ifdef ALU_MUL_EN
    else if (ld_mul) begin
      vld_d = 1'b1;
      alu_d = macc_q;
      rd2_d = mrd2_q;
      eq_d  = meq_q;
      rdo_d = mrd_q;
      wr_d  = mwr_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      alu_q <= '0;
      rd2_q <= '0;
      eq_q  <= 1'b0;
      rdo_q <= '0;
      wr_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      alu_q <= alu_d;
      rd2_q <= rd2_d;
      eq_q  <= eq_d;
      rdo_q <= rdo_d;
      wr_q  <= wr_d;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.alu_out   = alu_q;
  assign bus.rd2_out   = rd2_q;
  assign bus.eq        = eq_q;
  assign bus.rd_out    = rdo_q;
  assign bus.wr_out    = wr_q;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Testbench for alu_regfile_pipe: vector table, directed corner cases
// and random operations against a register-array reference model.
module tb_alu_regfile_pipe;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  alu_regfile_pipe_if #(.XLEN(XLEN), .NREGS(NREGS)) ifc ();

  alu_regfile_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk;
  int n_fail;
  logic [31:0] R [32];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op,
      input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    int sh;
    sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return $unsigned($signed(a) >>> sh);
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9: return (a < b) ? 32'd1 : 32'd0;
      10: begin
        p = longint'(a) * longint'(b);
        return MUL_EN ? p[31:0] : 32'd0;
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a,
      input logic w, input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (w && wa == a) return wd;
    return R[a];
  endfunction

  task automatic idle_inputs();
    ifc.in_valid  = 1'b0;
    ifc.rs1       = '0;
    ifc.rs2       = '0;
    ifc.rd        = '0;
    ifc.reg_write = 1'b0;
    ifc.alu_src   = 1'b0;
    ifc.alu_ctrl  = '0;
    ifc.imm       = '0;
    ifc.wb_en     = 1'b0;
    ifc.wb_addr   = '0;
    ifc.wb_data   = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    ifc.wb_en   = 1'b1;
    ifc.wb_addr = a;
    ifc.wb_data = d;
    @(negedge clk);
    ifc.wb_en = 1'b0;
    if (a != 0) R[a] = d;
  endtask

  // Called at a negedge; returns at a negedge with the result visible.
  task automatic run_op(input string nm, input logic [3:0] op,
      input logic [4:0] r1, input logic [4:0] r2,
      input logic [4:0] rdst, input logic src,
      input logic [31:0] im, input logic w,
      input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] a;
    logic [31:0] v2;
    logic [31:0] b;
    logic [31:0] e;
    logic        wr;
    int k;
    k = 0;
    while (!ifc.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_rdy"}, 32'(ifc.in_ready), 32'd1);
    a  = rd_model(r1, w, wa, wd);
    v2 = rd_model(r2, w, wa, wd);
    b  = src ? im : v2;
    e  = ref_alu(int'(op), a, b);
    wr = $urandom_range(0, 1) == 1;
    ifc.in_valid  = 1'b1;
    ifc.alu_ctrl  = op;
    ifc.rs1       = r1;
    ifc.rs2       = r2;
    ifc.rd        = rdst;
    ifc.reg_write = wr;
    ifc.alu_src   = src;
    ifc.imm       = im;
    ifc.wb_en     = w;
    ifc.wb_addr   = wa;
    ifc.wb_data   = wd;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    ifc.wb_en    = 1'b0;
    if (w && wa != 0) R[wa] = wd;
    k = 0;
    while (!ifc.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_valid"}, 32'(ifc.out_valid), 32'd1);
    chk({nm, "_alu"}, ifc.alu_out, e);
    chk({nm, "_eq"}, 32'(ifc.eq), 32'(a == b));
    chk({nm, "_rd2"}, ifc.rd2_out, v2);
    chk({nm, "_rd"}, 32'(ifc.rd_out), 32'(rdst));
    chk({nm, "_wr"}, 32'(ifc.wr_out), 32'(wr));
  endtask

  initial begin
    logic [31:0] hold_exp;
    logic [31:0] xor_exp;
    int k;
    bit seen;
    bit busy;

    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 32; i++) R[i] = '0;

    tbl[0]  = '{4'd0,  32'd7,          32'd3,      32'd10};
    tbl[1]  = '{4'd1,  32'd5,          32'd7,      32'hFFFFFFFE};
    tbl[2]  = '{4'd2,  32'h0000F0F0,   32'hFF00,   32'h0000F000};
    tbl[3]  = '{4'd3,  32'h0000F0F0,   32'hFF00,   32'h0000FFF0};
    tbl[4]  = '{4'd4,  32'h0000F0F0,   32'hFF00,   32'h00000FF0};
    tbl[5]  = '{4'd5,  32'd1,          32'd31,     32'h80000000};
    tbl[6]  = '{4'd5,  32'd1,          32'd33,     32'd2};
    tbl[7]  = '{4'd6,  32'h80000000,   32'd4,      32'h08000000};
    tbl[8]  = '{4'd7,  32'h80000000,   32'd4,      32'hF8000000};
    tbl[9]  = '{4'd8,  32'h80000000,   32'd1,      32'd1};
    tbl[10] = '{4'd9,  32'h80000000,   32'd1,      32'd0};
    tbl[11] = '{4'd0,  32'hFFFFFFFF,   32'd1,      32'd0};
    tbl[12] = '{4'd15, 32'h12345678,   32'd9,      32'd0};
    tbl[13] = '{4'd11, 32'h12345678,   32'd9,      32'd0};
    tbl[14] = '{4'd10, 32'd7,          32'd6,
                MUL_EN ? 32'd42 : 32'd0};
    tbl[15] = '{4'd10, 32'hFFFFFFFF,   32'd2,
                MUL_EN ? 32'hFFFFFFFE : 32'd0};

    idle_inputs();
    ifc.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_alu", ifc.alu_out, 32'd0);
    chk("rst_rd2", ifc.rd2_out, 32'd0);
    chk("rst_eq", 32'(ifc.eq), 32'd0);
    chk("rst_rdo", 32'(ifc.rd_out), 32'd0);
    chk("rst_wr", 32'(ifc.wr_out), 32'd0);
    chk("rst_ready", 32'(ifc.in_ready), 32'd1);
    chk("rst_a0", ifc.a0, 32'd0);

    // Write then add immediate
    wb(5'd5, 32'd7);
    run_op("t1_add", 4'd0, 5'd5, 5'd0, 5'd3, 1'b1, 32'd3,
           1'b0, 5'd0, 32'd0);
    chk("t1_alu10", ifc.alu_out, 32'd10);

    // Bypass of a same-cycle write, and x0 stays zero
    run_op("t2_byp", 4'd1, 5'd6, 5'd0, 5'd4, 1'b0, 32'd0,
           1'b1, 5'd6, 32'h20);
    chk("t2_byp20", ifc.alu_out, 32'h20);
    chk("t2_eq0", 32'(ifc.eq), 32'd0);
    wb(5'd0, 32'hFF);
    run_op("t2_x0", 4'd0, 5'd0, 5'd0, 5'd1, 1'b1, 32'd0,
           1'b1, 5'd0, 32'hFF);
    chk("t2_x0val", ifc.alu_out, 32'd0);

    // a0 is not bypassed: old value during the write cycle
    wb(5'd10, 32'h1234);
    chk("a0_wr", ifc.a0, 32'h1234);
    ifc.wb_en   = 1'b1;
    ifc.wb_addr = 5'd10;
    ifc.wb_data = 32'h5678;
    #1;
    chk("a0_nobyp", ifc.a0, 32'h1234);
    @(negedge clk);
    ifc.wb_en = 1'b0;
    R[10] = 32'h5678;
    chk("a0_new", ifc.a0, 32'h5678);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      wb(5'd1, tbl[i].a);
      run_op($sformatf("tbl%0d", i), tbl[i].op, 5'd1, 5'd2,
             5'(i), 1'b1, tbl[i].b, 1'b0, 5'd0, 32'd0);
      chk($sformatf("tbl%0d_exp", i), ifc.alu_out, tbl[i].exp);
    end

    // Output hold under back-pressure
    wb(5'd1, 32'h00C0FFEE);
    ifc.out_ready = 1'b0;
    hold_exp = ref_alu(0, R[1], 32'd5);
    xor_exp  = ref_alu(4, R[1], 32'hFF);
    run_op("hold_a", 4'd0, 5'd1, 5'd0, 5'd9, 1'b1, 32'd5,
           1'b0, 5'd0, 32'd0);
    ifc.in_valid  = 1'b1;
    ifc.alu_ctrl  = 4'd4;
    ifc.rs1       = 5'd1;
    ifc.alu_src   = 1'b1;
    ifc.imm       = 32'hFF;
    ifc.rd        = 5'd11;
    ifc.reg_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_rdy", 32'(ifc.in_ready), 32'd0);
      chk("hold_vld", 32'(ifc.out_valid), 32'd1);
      chk("hold_alu", ifc.alu_out, hold_exp);
      chk("hold_rd", 32'(ifc.rd_out), 32'd9);
      @(negedge clk);
    end
    ifc.out_ready = 1'b1;
    #1;
    chk("hold_release_rdy", 32'(ifc.in_ready), 32'd1);
    @(negedge clk);
    ifc.in_valid = 1'b0;
    chk("hold_next_vld", 32'(ifc.out_valid), 32'd1);
    chk("hold_next_alu", ifc.alu_out, xor_exp);
    chk("hold_next_rd", 32'(ifc.rd_out), 32'd11);
    @(negedge clk);
    chk("hold_drop", 32'(ifc.out_valid), 32'd0);

    // Multiply latency and in_ready during the iteration
    wb(5'd1, 32'd7);
    ifc.in_valid = 1'b1;
    ifc.alu_ctrl = 4'd10;
    ifc.rs1      = 5'd1;
    ifc.alu_src  = 1'b1;
    ifc.imm      = 32'd6;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    k = 0;
    busy = 1'b0;
    while (!ifc.out_valid && k < 200) begin
      if (ifc.in_ready) busy = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("mul_lat", 32'(k), MUL_EN ? 32'd33 : 32'd0);
    chk("mul_busy_rdy", 32'(busy), 32'd0);
    chk("mul_val", ifc.alu_out, MUL_EN ? 32'd42 : 32'd0);

    // Operands are captured at accept
    wb(5'd2, 32'd9);
    ifc.in_valid = 1'b1;
    ifc.alu_ctrl = 4'd10;
    ifc.rs1      = 5'd2;
    ifc.alu_src  = 1'b1;
    ifc.imm      = 32'd3;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    wb(5'd2, 32'd100);
    k = 0;
    while (!ifc.out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("mul_snap", ifc.alu_out, MUL_EN ? 32'd27 : 32'd0);

    // Reset in the middle of a multiply
    wb(5'd1, 32'd5);
    ifc.in_valid = 1'b1;
    ifc.alu_ctrl = 4'd10;
    ifc.rs1      = 5'd1;
    ifc.alu_src  = 1'b1;
    ifc.imm      = 32'd5;
    @(negedge clk);
    ifc.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) R[i] = '0;
    @(negedge clk);
    chk("rmul_vld", 32'(ifc.out_valid), 32'd0);
    chk("rmul_rdy", 32'(ifc.in_ready), 32'd1);
    chk("rmul_a0", ifc.a0, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (ifc.out_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("rmul_noresult", 32'(seen), 32'd0);
    run_op("rmul_x1", 4'd0, 5'd1, 5'd5, 5'd1, 1'b1, 32'd0,
           1'b0, 5'd0, 32'd0);
    chk("rmul_x1z", ifc.alu_out, 32'd0);
    chk("rmul_x5z", ifc.rd2_out, 32'd0);
    run_op("rmul_x10", 4'd3, 5'd10, 5'd2, 5'd1, 1'b0, 32'd0,
           1'b0, 5'd0, 32'd0);
    chk("rmul_x10z", ifc.alu_out, 32'd0);

    // Random operations against the register model
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        wb(5'($urandom_range(0, 31)), $urandom);
      end
      run_op($sformatf("rnd%0d", n),
             4'($urandom_range(0, 15)),
             5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ?
               32'($urandom_range(0, 40)) : $urandom,
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)),
             $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
